// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register stage with an optional skid entry.
//
// Purpose:
//   Passes payloads from an upstream valid/ready interface to a downstream
//   valid/ready interface with one cycle of latency. Payloads leave in the
//   order they were accepted. out_data always comes straight from a flop.
//
//   SKID_EN=1: two entries (output register + skid register). in_ready is a
//              flop, so there is no combinational path from out_ready to in_ready.
//   SKID_EN=0: one entry (output register only). in_ready = !out_valid || out_ready,
//              which is combinational.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   flush      in   synchronous kill of all held entries and of the payload offered this cycle
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload [DATA_W-1:0]
//   out_valid  out  downstream payload valid
//   out_ready  in   downstream accepts this cycle
//   out_data   out  downstream payload [DATA_W-1:0]
//   occupancy  out  number of held entries, 0..2 (registered)
module pipe_skid_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                SKID_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [1:0]        occ_q,       occ_d;

  // Room in the output register this cycle: it is empty or is being drained.
  logic out_free;
  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= RESET_DATA;
      occ_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      occ_q       <= occ_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occupancy = occ_q;

  if (SKID_EN != 0) begin : g_skid
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q;
    logic              accept;

    // A payload offered during a flush is dropped, even if in_ready is high.
    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
        // Only the valid flags drop; the data flops keep their contents.
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end else if (out_free) begin
        if (skid_valid_q) begin
          // in_ready is low whenever the skid entry is full, so no accept
          // can coincide with this refill.
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        // Output is stalled: park the new payload in the skid entry.
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end

    assign occ_d = {1'b0, out_valid_d} + {1'b0, skid_valid_d};

    always_ff @(posedge clk) begin
      if (rst) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= RESET_DATA;
        in_ready_q   <= 1'b1;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
        in_ready_q   <= !skid_valid_d;
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    logic accept;

    assign in_ready = out_free;
    assign accept   = in_valid && out_free && !flush;

    always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (flush) begin
        out_valid_d = 1'b0;
      end else if (out_free) begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end
    end

    assign occ_d = {1'b0, out_valid_d};
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg.
// Three instances share the control inputs:
//   0: DATA_W=64, SKID_EN=1   1: DATA_W=8, SKID_EN=1   2: DATA_W=64, SKID_EN=0
// The reference model is a small in-order list of held payloads per instance.
module tb_pipe_skid_reg;

  localparam logic [63:0] RST0 = 64'hA5A5_0000_FFFF_1234;
  localparam logic [7:0]  RST1 = 8'h3C;
  localparam logic [63:0] RST2 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [63:0] od0, od2;
  logic [7:0]  od1;
  logic [1:0]  oc0, oc1, oc2;

  pipe_skid_reg #(.DATA_W(64), .RESET_DATA(RST0), .SKID_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0));

  pipe_skid_reg #(.DATA_W(8), .RESET_DATA(RST1), .SKID_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data[7:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1));

  pipe_skid_reg #(.DATA_W(64), .RESET_DATA(RST2), .SKID_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(oc2));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: held payloads in acceptance order, plus the value the
  // output register is expected to show (last loaded payload when empty).
  logic [63:0] m_mem  [3][2];
  int          m_cnt  [3];
  logic [63:0] m_show [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_rdy(input int k, input logic ordy);
    if (k == 2) return (m_cnt[k] == 0) || ordy;
    return m_cnt[k] < 2;
  endfunction

  function automatic logic [63:0] reset_val(input int k);
    if (k == 0) return RST0;
    if (k == 1) return {56'b0, RST1};
    return RST2;
  endfunction

  task automatic check_all();
    if (chk_en) begin
      chk("in_ready0",  {63'b0, ir0}, {63'b0, exp_rdy(0, out_ready)});
      chk("out_valid0", {63'b0, ov0}, {63'b0, m_cnt[0] > 0});
      chk("out_data0",  od0, m_show[0]);
      chk("occupancy0", {62'b0, oc0}, 64'(m_cnt[0]));
      chk("in_ready1",  {63'b0, ir1}, {63'b0, exp_rdy(1, out_ready)});
      chk("out_valid1", {63'b0, ov1}, {63'b0, m_cnt[1] > 0});
      chk("out_data1",  {56'b0, od1}, m_show[1]);
      chk("occupancy1", {62'b0, oc1}, 64'(m_cnt[1]));
      chk("in_ready2",  {63'b0, ir2}, {63'b0, exp_rdy(2, out_ready)});
      chk("out_valid2", {63'b0, ov2}, {63'b0, m_cnt[2] > 0});
      chk("out_data2",  od2, m_show[2]);
      chk("occupancy2", {62'b0, oc2}, 64'(m_cnt[2]));
    end
  endtask

  task automatic model_update(input logic r, input logic f, input logic iv,
                              input logic [63:0] d, input logic ordy);
    for (int k = 0; k < 3; k++) begin
      logic        rdy, dlv, acc;
      logic [63:0] mask;
      mask = (k == 1) ? 64'hFF : '1;
      rdy  = exp_rdy(k, ordy);
      if (r) begin
        m_cnt[k]  = 0;
        m_show[k] = reset_val(k);
      end else if (f) begin
        m_cnt[k] = 0;
      end else begin
        dlv = (m_cnt[k] > 0) && ordy;
        acc = iv && rdy;
        if (dlv) begin
          m_mem[k][0] = m_mem[k][1];
          m_cnt[k]--;
        end
        if (acc) begin
          m_mem[k][m_cnt[k]] = d & mask;
          m_cnt[k]++;
        end
        if (m_cnt[k] > 0) m_show[k] = m_mem[k][0];
      end
    end
  endtask

  // Called just after a falling edge: drive, check, clock, update model.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [63:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1 check_all();
    @(posedge clk);
    model_update(r, f, iv, d, ordy);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_show[k] = '0;
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    cyc(1, 0, 1, 64'hFFFF, 1);
    cyc(1, 1, 1, 64'hEEEE, 0);
    chk_en = 1'b1;

    // Reset state
    chk("rst_data0", od0, RST0);
    chk("rst_data1", {56'b0, od1}, {56'b0, RST1});
    chk("rst_occ0",  {62'b0, oc0}, 64'd0);
    chk("rst_rdy0",  {63'b0, ir0}, 64'd1);

    // Streaming from the first edge with rst low
    cyc(0, 0, 1, 64'h1, 1);
    chk("stream1", od0, 64'h1);
    cyc(0, 0, 1, 64'h2, 1);
    chk("stream2", od0, 64'h2);
    cyc(0, 0, 1, 64'h3, 1);
    chk("stream3", od0, 64'h3);
    chk("stream_occ", {62'b0, oc0}, 64'd1);
    cyc(0, 0, 0, 64'h55, 1);
    chk("stream_drain", {63'b0, ov0}, 64'd0);

    // Backpressure into the skid entry
    cyc(0, 0, 1, 64'hA, 0);
    cyc(0, 0, 1, 64'hB, 0);
    chk("bp_hold", od0, 64'hA);
    chk("bp_occ",  {62'b0, oc0}, 64'd2);
    chk("bp_rdy",  {63'b0, ir0}, 64'd0);
    cyc(0, 0, 1, 64'h77, 1);
    chk("bp_second", od0, 64'hB);
    chk("bp_rdy_back", {63'b0, ir0}, 64'd1);
    cyc(0, 0, 0, 64'h0, 1);
    chk("bp_empty", {62'b0, oc0}, 64'd0);

    // Flush drops held entries and the payload offered with it
    cyc(0, 0, 1, 64'hA, 0);
    cyc(0, 0, 1, 64'hB, 0);
    cyc(0, 1, 1, 64'hC, 0);
    chk("fl_valid", {63'b0, ov0}, 64'd0);
    chk("fl_occ",   {62'b0, oc0}, 64'd0);
    chk("fl_rdy",   {63'b0, ir0}, 64'd1);
    chk("fl_data_held", od0, 64'hA);
    cyc(0, 0, 0, 64'hC, 1);
    cyc(0, 0, 0, 64'hC, 1);
    chk("fl_no_c", {63'b0, ov0}, 64'd0);
    cyc(0, 1, 0, 64'h99, 1);
    chk("fl_empty_noop", od0, 64'hA);

    // Reset mid-operation beats flush and accept
    cyc(0, 0, 1, 64'hA, 0);
    cyc(0, 0, 1, 64'hB, 0);
    cyc(1, 1, 1, 64'hC, 1);
    chk("rm_valid", {63'b0, ov0}, 64'd0);
    chk("rm_data",  od0, RST0);
    chk("rm_rdy",   {63'b0, ir0}, 64'd1);
    cyc(0, 0, 0, 64'h0, 1);
    chk("rm_no_dlv", {63'b0, ov0}, 64'd0);

    // Single-entry mode: in_ready follows out_ready within the cycle
    cyc(0, 0, 1, 64'h5, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'h6; out_ready = 1'b0;
    #1 chk("ns_rdy_lo", {63'b0, ir2}, 64'd0);
    out_ready = 1'b1;
    #1 chk("ns_rdy_hi", {63'b0, ir2}, 64'd1);
    cyc(0, 0, 1, 64'h6, 1);
    chk("ns_pass_data",  od2, 64'h6);
    chk("ns_pass_valid", {63'b0, ov2}, 64'd1);
    cyc(0, 0, 0, 64'h0, 1);
    cyc(0, 0, 0, 64'h0, 1);

    // Random valid/ready stress
    for (int i = 0; i < 10000; i++) begin
      logic        r, f, iv, ordy;
      logic [63:0] d;
      int          bias;
      bias = (i / 1000) % 4;
      r    = ($urandom_range(0, 599) == 0);
      f    = ($urandom_range(0, 79) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) < bias + 1) && ($urandom_range(0, 7) != 0);
      d    = {$urandom, $urandom};
      cyc(r, f, iv, d, ordy);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 64'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
